// File: rtl/pc_pkg.sv
// Shared definitions for the PC unit: branch condition codes and control FSM states.
package pc_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } pc_state_e;

endpackage

// File: rtl/branch_cond.sv
// Resolves a conditional branch from funct3 and the flags of the A-B subtract.
module branch_cond
    import pc_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       Z,
    input  logic       N,
    input  logic       V,
    input  logic       C,
    output logic       cond
);

    // C is the no-borrow flag, so A >= B unsigned when C is set.
    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = Z;
            F3_BNE:  cond = ~Z;
            F3_BLT:  cond = N ^ V;
            F3_BGE:  cond = ~(N ^ V);
            F3_BLTU: cond = ~C;
            F3_BGEU: cond = C;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with branch/JAL/JALR target select, stall, retire counter and
// a halting trap on misaligned control-transfer targets.
module pc_unit
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        branch,
    input  logic        jump,
    input  logic        jalr,
    input  logic [2:0]  funct3,
    input  logic        Z,
    input  logic        N,
    input  logic        V,
    input  logic        C,
    input  logic [31:0] imm_ext,
    input  logic [31:0] alu_result,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        taken,
    output logic        trap,
    output logic [31:0] trap_addr,
    output logic [31:0] instret
);

    pc_state_e   state_q;
    logic [31:0] pc_q;
    logic [31:0] trap_addr_q;
    logic [31:0] instret_q;
    logic        trap_q;

    logic        br_cond;
    logic        advance;
    logic [31:0] target_d;

    branch_cond u_branch_cond (
        .funct3 (funct3),
        .Z      (Z),
        .N      (N),
        .V      (V),
        .C      (C),
        .cond   (br_cond)
    );

    assign pc_plus4 = pc_q + 32'd4;
    assign taken    = (state_q == ST_RUN) & (jalr | jump | (branch & br_cond));
    assign advance  = imem_ready & ~stall;

    // jalr wins over jump, which wins over a taken branch.
    always_comb begin
        target_d = pc_plus4;
        if (jalr) begin
            target_d = alu_result & ~32'h1;
        end else if (jump || (branch && br_cond)) begin
            target_d = pc_q + imm_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            trap_q      <= 1'b0;
            trap_addr_q <= 32'h0;
            instret_q   <= 32'h0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (advance) begin
                        if (taken && (target_d[1:0] != 2'b00)) begin
                            state_q     <= ST_HALT;
                            trap_q      <= 1'b1;
                            trap_addr_q <= target_d;
                        end else begin
                            pc_q      <= target_d;
                            instret_q <= instret_q + 32'd1;
                        end
                    end
                end
                ST_HALT: begin
                    trap_q <= 1'b1;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign pc        = pc_q;
    assign trap      = trap_q;
    assign trap_addr = trap_addr_q;
    assign instret   = instret_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a driver issues directed then random cycles and
// queues the expected outputs from a reference model; a monitor pops and compares.
module tb_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_ready = 1'b0;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic        jump = 1'b0;
    logic        jalr = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic        Z = 1'b0, N = 1'b0, V = 1'b0, C = 1'b0;
    logic [31:0] imm_ext = 32'h0;
    logic [31:0] alu_result = 32'h0;
    logic [31:0] pc, pc_plus4, trap_addr, instret;
    logic        taken, trap;

    pc_unit #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_ready (imem_ready),
        .stall      (stall),
        .branch     (branch),
        .jump       (jump),
        .jalr       (jalr),
        .funct3     (funct3),
        .Z          (Z),
        .N          (N),
        .V          (V),
        .C          (C),
        .imm_ext    (imm_ext),
        .alu_result (alu_result),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .taken      (taken),
        .trap       (trap),
        .trap_addr  (trap_addr),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        tk;
        logic        trap;
        logic [31:0] ta;
        logic [31:0] ir;
    } exp_t;

    exp_t q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Reference model state: architectural view, no FSM encoding.
    logic [31:0] m_pc = 32'h0, m_ta = 32'h0, m_ir = 32'h0;
    bit          m_halted = 1'b0;
    bit          m_known  = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            if (e.chk) begin
                cmp("pc",        pc,        e.pc);
                cmp("pc_plus4",  pc_plus4,  e.pc4);
                cmp("taken",     {31'h0, taken}, {31'h0, e.tk});
                cmp("trap",      {31'h0, trap},  {31'h0, e.trap});
                cmp("trap_addr", trap_addr, e.ta);
                cmp("instret",   instret,   e.ir);
            end
        end
    end

    // One cycle: flags derive from a real A-B subtract; the model judges the
    // branch by comparing A and B directly.
    task automatic step(input bit r, input bit rdy, input bit st, input bit br,
                        input bit jm, input bit jr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [31:0] alu);
        logic [31:0] diff, tgt;
        bit          cond, tk;
        exp_t        e;
        @(posedge clk);
        #1;
        diff = a - b;
        rst = r; imem_ready = rdy; stall = st; branch = br; jump = jm; jalr = jr;
        funct3 = f3; imm_ext = imm; alu_result = alu;
        Z = (diff == 32'h0);
        N = diff[31];
        V = (a[31] != b[31]) && (diff[31] != a[31]);
        C = (a >= b);
        case (f3)
            3'b000: cond = (a == b);
            3'b001: cond = (a != b);
            3'b100: cond = ($signed(a) <  $signed(b));
            3'b101: cond = ($signed(a) >= $signed(b));
            3'b110: cond = (a <  b);
            3'b111: cond = (a >= b);
            default: cond = 1'b0;
        endcase
        tk  = !m_halted && (jr || jm || (br && cond));
        tgt = jr ? (alu & 32'hFFFF_FFFE) : ((jm || (br && cond)) ? m_pc + imm : m_pc + 32'd4);
        e.chk = m_known; e.pc = m_pc; e.pc4 = m_pc + 32'd4; e.tk = tk;
        e.trap = m_halted; e.ta = m_ta; e.ir = m_ir;
        q.push_back(e);
        if (r) begin
            m_pc = RST_PC; m_ta = 32'h0; m_ir = 32'h0; m_halted = 1'b0; m_known = 1'b1;
        end else if (!m_halted && rdy && !st) begin
            if (tk && tgt[1:0] != 2'b00) begin
                m_halted = 1'b1; m_ta = tgt;
            end else begin
                m_pc = tgt; m_ir = m_ir + 32'd1;
            end
        end
    endtask

    task automatic seq(input bit rdy);
        step(0, rdy, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic go_to(input logic [31:0] addr);
        step(0, 1, 0, 0, 0, 1, 3'b000, 32'h0, 32'h0, 32'h0, addr);
    endtask

    task automatic br_at_100(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        go_to(32'h100);
        step(0, 1, 0, 1, 0, 0, f3, a, b, 32'h20, 32'h0);
        seq(0);
    endtask

    initial begin
        bit r, rdy, st, br, jm, jr;
        logic [31:0] a, b, imm, alu;
        // Reset, then sequential fetch: 0,4,8,12 with instret 3.
        step(1, 1, 0, 1, 1, 1, 3'b000, 32'h5, 32'h5, 32'h7, 32'h33);
        seq(1); seq(1); seq(1); seq(0); seq(0);
        // Branch outcomes from pc 0x100 with offset 0x20.
        br_at_100(3'b000, 32'h1234, 32'h1234);         // BEQ taken -> 0x120
        br_at_100(3'b100, 32'h7FFF_FFFF, 32'hFFFF_FFFF); // N=1 V=1, not less -> 0x104
        br_at_100(3'b111, 32'h9, 32'h3);               // BGEU taken -> 0x120
        br_at_100(3'b010, 32'h0, 32'h0);               // reserved code -> 0x104
        br_at_100(3'b110, 32'h3, 32'h9);               // BLTU taken
        br_at_100(3'b001, 32'h3, 32'h3);               // BNE not taken
        // Priority: jalr beats jump and branch, LSB cleared -> 0x200.
        go_to(32'h100);
        step(0, 1, 0, 1, 1, 1, 3'b000, 32'h1, 32'h1, 32'h40, 32'h201);
        seq(0);
        // Stall holds across a jump, then the jump lands.
        step(0, 1, 1, 0, 1, 0, 3'b000, 32'h0, 32'h0, 32'h40, 32'h0);
        step(0, 1, 1, 0, 1, 0, 3'b000, 32'h0, 32'h0, 32'h40, 32'h0);
        step(0, 1, 0, 0, 1, 0, 3'b000, 32'h0, 32'h0, 32'h40, 32'h0);
        seq(0);
        // Misaligned jump traps and holds through noisy inputs until reset.
        go_to(32'h100);
        step(0, 1, 0, 0, 1, 0, 3'b000, 32'h0, 32'h0, 32'h6, 32'h0);
        for (int i = 0; i < 5; i++)
            step(0, 1, 0, 1, 1, 1, 3'($urandom), $urandom, $urandom, $urandom, $urandom);
        step(1, 1, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
        seq(0);
        // Misaligned jalr target (bit 1 set) also traps.
        step(0, 1, 0, 0, 0, 1, 3'b000, 32'h0, 32'h0, 32'h0, 32'h303);
        seq(1);
        step(1, 0, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
        // PC wraps past the top of the address space.
        go_to(32'hFFFF_FFFC);
        seq(1); seq(0);
        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 59) == 0) || (m_halted && $urandom_range(0, 5) == 0);
            rdy = ($urandom_range(0, 9) < 8);
            st  = ($urandom_range(0, 9) < 2);
            br  = ($urandom_range(0, 9) < 4);
            jm  = ($urandom_range(0, 9) < 2);
            jr  = ($urandom_range(0, 9) < 2);
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) b = {a[31], b[30:0]};
            imm = (32'($urandom_range(0, 255)) - 32'd128) << 2;
            if ($urandom_range(0, 19) == 0) imm = imm + 32'($urandom_range(1, 3));
            alu = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) alu = alu | 32'($urandom_range(0, 3));
            else if ($urandom_range(0, 3) == 0) alu = alu | 32'h1;
            step(r, rdy, st, br, jm, jr, 3'($urandom), a, b, imm, alu);
        end
        seq(0);
        repeat (3) @(posedge clk);
        cmp("queue_drained", 32'(q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 imem_ready  in  1  instruction memory accepted the current PC.
REQ-005 stall  in  1  hold PC; has priority over imem_ready.
REQ-006 branch  in  1  current instruction is a conditional branch.
REQ-007 jump  in  1  current instruction is JAL.
REQ-008 jalr  in  1  current instruction is JALR.
REQ-009 funct3  in  3  branch condition code.
REQ-010 Z, N, V, C  in  1 each  ALU flags from the A-B subtract of the current instruction.
REQ-011 imm_ext  in  32  sign-extended branch/JAL offset.
REQ-012 alu_result  in  32  JALR target before LSB clear.
REQ-013 pc  out  32  current PC register.
REQ-014 pc_plus4  out  32  pc + 4, combinational.
REQ-015 taken  out  1  combinational: current control transfer is taken.
REQ-016 trap  out  1  registered: unit halted on a misaligned target.
REQ-017 trap_addr  out  32  registered: offending target address.
REQ-018 instret  out  32  registered count of PC advances.

Function
REQ-019 Branch resolve: 000 BEQ=Z; 001 BNE=~Z; 100 BLT=N^V; 101 BGE=~(N^V); 110 BLTU=~C; 111 BGEU=C; 010/011 SHALL resolve not-taken.
REQ-020 taken SHALL equal jalr | jump | (branch & resolve), forced 0 while state is HALT.
REQ-021 Target: jalr -> alu_result & ~32'h1; else jump or taken branch -> pc + imm_ext; else pc_plus4; all sums modulo 2^32, no overflow detection.
REQ-022 Select priority SHALL be jalr > jump > branch > sequential; multiple asserted flags SHALL NOT be an error.
REQ-023 FSM states: RUN, HALT.
REQ-024 RUN, advance = imem_ready & ~stall: if taken and target[1:0] != 2'b00, go to HALT, set trap=1, trap_addr=target, and leave pc unchanged.
REQ-025 RUN, advance with aligned target: pc <= target, instret <= instret + 1 (wraps 32'hFFFF_FFFF -> 0).
REQ-026 RUN without advance: pc, instret, trap_addr SHALL hold; flag and funct3 inputs are ignored.
REQ-027 HALT: pc, instret, trap_addr SHALL hold and trap SHALL stay 1 until rst; all other inputs are ignored.
REQ-028 The PC update SHALL occur one edge after advance is sampled; there are no other pipeline registers.

Reset
REQ-029 On rst at a clock edge: pc=RESET_PC, state=RUN, trap=0, trap_addr=0, instret=0, overriding all other inputs, including in HALT or mid-stall.
REQ-030 The first advance after reset release SHALL present RESET_PC on pc for at least one cycle.

Structure
REQ-031 Shared package pc_pkg SHALL hold the funct3 branch-code localparams and the RUN/HALT state enum.
REQ-032 One combinational sub-module, branch_cond (funct3, Z, N, V, C -> cond), SHALL implement REQ-019.
REQ-033 pc_unit SHALL contain the PC, FSM, trap, and instret registers, plus the target mux.

Verification
REQ-034 Sequential: rst then imem_ready=1, no control, 3 cycles -> pc 0,4,8,12; instret=3.
REQ-035 Branches: pc=0x100, branch=1, imm_ext=0x20. BEQ Z=1 -> 0x120. BLT N=1 V=1 -> 0x104. BGEU C=1 -> 0x120. funct3=010 -> 0x104.
REQ-036 Priority: jalr=jump=branch=1, alu_result=0x201, imm_ext=0x40, pc=0x100 -> pc=0x200.
REQ-037 Stall: stall=1 with jump=1 for 2 cycles -> pc and instret unchanged; release stall -> pc jumps.
REQ-038 Trap: jump=1, pc=0x100, imm_ext=0x6 -> trap=1, trap_addr=0x106, pc=0x100, held for 5 cycles; rst -> pc=RESET_PC, trap=0.
REQ-039 Wrap: pc=0xFFFF_FFFC, sequential advance -> pc=0; preload instret to 0xFFFF_FFFF, advance -> instret=0.
